tx_lp_sequencer: RTL

- Moore FSM that sequences the C-PHY lane's low-power line states for three operations: HS entry/exit, escape entry/exit and bus turnaround.
- Drives the 2-bit `TxCtrlOut` code into the lane's LP control decoder, which maps it to A/B/C line levels.
- Arbitrates the three request inputs and times every LP state with one shared down-counter.
- Sits between the lane protocol layer and the LP control decoder.

---
 rtl/cphy_lp_pkg.sv | 33 +++
 rtl/lp_state_timer.sv | 27 ++
 rtl/tx_lp_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cphy_lp_pkg.sv
// rtl/cphy_lp_pkg.sv - shared C-PHY LP line-state codes, sequencer states and op encodings.
package cphy_lp_pkg;

    localparam logic [1:0] CTRL_STOP   = 2'b00;
    localparam logic [1:0] CTRL_RQST   = 2'b01;
    localparam logic [1:0] CTRL_BRIDGE = 2'b10;
    localparam logic [1:0] CTRL_LPRQST = 2'b11;

    typedef enum logic [3:0] {
        ST_STOP       = 4'd0,
        ST_HS_RQST    = 4'd1,
        ST_HS_PREP    = 4'd2,
        ST_HS_ACTIVE  = 4'd3,
        ST_HS_EXIT    = 4'd4,
        ST_LP_RQST    = 4'd5,
        ST_LP_YIELD   = 4'd6,
        ST_ESC_RQST   = 4'd7,
        ST_ESC_GO     = 4'd8,
        ST_ESC_ACTIVE = 4'd9,
        ST_ESC_EXIT   = 4'd10,
        ST_TA_RQST    = 4'd11,
        ST_TA_GO      = 4'd12,
        ST_TA_RX      = 4'd13
    } lp_state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_HS   = 2'd1,
        OP_ESC  = 2'd2,
        OP_TA   = 2'd3
    } lp_op_t;

endpackage

// File: rtl/lp_state_timer.sv
// rtl/lp_state_timer.sv - loadable down-counter that saturates at zero, with zero flag.
module lp_state_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tx_lp_sequencer.sv
// rtl/tx_lp_sequencer.sv - C-PHY lane LP-state sequencer for HS entry/exit, escape and turnaround.
module tx_lp_sequencer #(
    parameter int TLPX_CYC     = 4,
    parameter int THS_PREP_CYC = 6,
    parameter int THS_EXIT_CYC = 8,
    parameter int TA_GO_CYC    = 16,
    parameter int CNT_W        = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TxRequestHS,
    input  logic       TxRequestEsc,
    input  logic       TxTurnRequest,
    input  logic       RxTurnBack,
    output logic [1:0] TxCtrlOut,
    output logic       TxReadyHS,
    output logic       TxEscActive,
    output logic       TxDirRx,
    output logic       TxTurnDone,
    output logic       Stopstate
);
    import cphy_lp_pkg::*;

    localparam logic [CNT_W-1:0] TLPX_LD     = CNT_W'(TLPX_CYC - 1);
    localparam logic [CNT_W-1:0] THS_PREP_LD = CNT_W'(THS_PREP_CYC - 1);
    localparam logic [CNT_W-1:0] THS_EXIT_LD = CNT_W'(THS_EXIT_CYC - 1);
    localparam logic [CNT_W-1:0] TA_GO_LD    = CNT_W'(TA_GO_CYC - 1);

    lp_state_t        state, state_next;
    lp_op_t           op, op_next;
    logic             ta_armed;
    logic             turn_first;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    lp_state_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (TLPX_LD)
    ) u_timer (
        .clk      (Clk),
        .rst      (Rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= ST_STOP;
            op         <= OP_NONE;
            ta_armed   <= 1'b1;
            turn_first <= 1'b0;
        end else begin
            state      <= state_next;
            op         <= op_next;
            turn_first <= (state == ST_TA_GO) && (state_next == ST_TA_RX);
            // A held TxTurnRequest must be seen low in STOP before it can start another turnaround.
            if (state == ST_STOP && state_next != ST_STOP && op_next == OP_TA) begin
                ta_armed <= 1'b0;
            end else if (state == ST_STOP && !TxTurnRequest) begin
                ta_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        op_next    = op;
        case (state)
            ST_STOP: begin
                if (tmr_zero) begin
                    if (TxRequestHS) begin
                        state_next = ST_HS_RQST;
                        op_next    = OP_HS;
                    end else if (TxRequestEsc) begin
                        state_next = ST_LP_RQST;
                        op_next    = OP_ESC;
                    end else if (TxTurnRequest && ta_armed) begin
                        state_next = ST_LP_RQST;
                        op_next    = OP_TA;
                    end
                end
            end
            ST_HS_RQST:    if (tmr_zero)      state_next = ST_HS_PREP;
            ST_HS_PREP:    if (tmr_zero)      state_next = ST_HS_ACTIVE;
            ST_HS_ACTIVE:  if (!TxRequestHS)  state_next = ST_HS_EXIT;
            ST_HS_EXIT:    if (tmr_zero)      state_next = ST_STOP;
            ST_LP_RQST:    if (tmr_zero)      state_next = ST_LP_YIELD;
            ST_LP_YIELD:   if (tmr_zero)      state_next = (op == OP_TA) ? ST_TA_RQST : ST_ESC_RQST;
            ST_ESC_RQST:   if (tmr_zero)      state_next = ST_ESC_GO;
            ST_ESC_GO:     if (tmr_zero)      state_next = ST_ESC_ACTIVE;
            ST_ESC_ACTIVE: if (!TxRequestEsc) state_next = ST_ESC_EXIT;
            ST_ESC_EXIT:   if (tmr_zero)      state_next = ST_STOP;
            ST_TA_RQST:    if (tmr_zero)      state_next = ST_TA_GO;
            ST_TA_GO:      if (tmr_zero)      state_next = ST_TA_RX;
            ST_TA_RX:      if (RxTurnBack)    state_next = ST_STOP;
            default:                          state_next = ST_STOP;
        endcase
    end

    // Every transition reloads the timer; untimed states simply ignore it.
    always_comb begin
        tmr_load = (state_next != state);
        case (state_next)
            ST_HS_PREP: tmr_val = THS_PREP_LD;
            ST_HS_EXIT: tmr_val = THS_EXIT_LD;
            ST_TA_GO:   tmr_val = TA_GO_LD;
            default:    tmr_val = TLPX_LD;
        endcase
    end

    always_comb begin
        case (state)
            ST_STOP, ST_TA_RX:                    TxCtrlOut = CTRL_STOP;
            ST_HS_RQST, ST_ESC_RQST:              TxCtrlOut = CTRL_RQST;
            ST_LP_RQST, ST_ESC_EXIT, ST_TA_RQST:  TxCtrlOut = CTRL_LPRQST;
            default:                              TxCtrlOut = CTRL_BRIDGE;
        endcase
    end

    assign TxReadyHS   = (state == ST_HS_ACTIVE);
    assign TxEscActive = (state == ST_ESC_ACTIVE);
    assign TxDirRx     = (state == ST_TA_RX);
    assign Stopstate   = (state == ST_STOP);
    assign TxTurnDone  = turn_first;

endmodule
